dot_feeder: RTL and testbench
=============================

# dot_feeder

Operand sequencer and result collector for the two-lane multiply-add pipeline, which computes C = A1·B1 + A2·B2 with a fixed 2-edge latency. Software loads two DEPTH-element vectors, then pulses start. The block issues element pairs to the pipeline on consecutive cycles, tracks in-flight pairs, and accumulates the returned C values into a 32-bit dot product. It sits between the control/register side and the pipeline, driving the pipeline's A1/A2/B1/B2 inputs and consuming its C output.

## Interface
- DEPTH, 8, elements per vector; even, ≥2; P = DEPTH/2 pairs
- LAT, 2, clk edges from the pipeline sampling operands to C updated
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- wr_en  in  1  buffer write strobe
- wr_sel  in  1  0 = vector A, 1 = vector B
- wr_addr  in  $clog2(DEPTH)  element index
- wr_data  in  32  element value
- start  in  1  begin a dot product; sampled in IDLE only
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse; result valid
- result  out  32  dot product, held until the next done
- A1, A2, B1, B2  out  32 each  operands to the pipeline (registered)
- C  in  32  pipeline output

## Operation
- Reset:
  - state=IDLE; busy=0, done=0, result=0.
  - A1/A2/B1/B2=0; accumulator=0; pair counter=0; valid tags cleared.
  - Buffer contents are not cleared.
- Writes: an edge with wr_en and busy=0 stores wr_data into A[wr_addr] or B[wr_addr]. Writes while busy are ignored.
- IDLE:
  - start=1 → ISSUE, busy←1, acc←0.
  - Operands load pair 0: A1=A[0], A2=A[1], B1=B[0], B2=B[1].
- ISSUE:
  - Each edge loads pair k: A1=A[2k], A2=A[2k+1], B1=B[2k], B2=B[2k+1].
  - After pair P−1 is loaded, the next edge zeroes the operands and the state moves to DRAIN.
- DRAIN: holds zero operands until the last tag is consumed.
- Valid tags:
  - LAT+1-bit shift register vld[0..LAT]. vld[0]=1 while the outputs carry a real pair; the register shifts every edge.
  - An edge with vld[LAT]=1 performs acc ← acc + C.
- Final add (the add for pair P−1):
  - result ← acc + C; done←1 for one cycle; busy←0; state→IDLE.
- start while busy is ignored. start in the done cycle is accepted, so back-to-back runs are allowed.
- Arithmetic: all sums are mod 2^32; no overflow flag. Products are truncated by the pipeline, not here.
- Reset mid-operation: aborts immediately to the reset values. done is not pulsed, and the in-flight C values are discarded.

## Timing
- Edge numbering: start is sampled at edge 0.
- Pair k:
  - on the operand outputs after edge k (k=0..P−1);
  - captured by the pipeline at edge k+1;
  - on C after edge k+LAT;
  - accumulated at edge k+LAT+1.
- Operands are zero after edge P.
- done is high in the cycle after edge P+LAT (edge 6 for DEPTH=8, LAT=2).
- busy covers edges 0 through P+LAT.
- Minimum start-to-start interval: P+LAT+1 cycles.
- DEPTH=2 (P=1): ISSUE lasts one edge; the FSM must not skip the DRAIN/tag logic.

## Structure
- Shared package dot_pkg:
  - state enum {IDLE, ISSUE, DRAIN};
  - localparam LAT_DEFAULT=2;
  - the operand width constant (32).
- One sub-module, dot_operand_buf: dual DEPTH×32 register file with one write port and two read ports. It reads the element pair (2k, 2k+1) of both vectors.
- The bench instantiates the existing multiply-add pipeline as the DUT's partner.

## Test plan
- A=1..8, B=all 1, start → done after edge 6, result=36; busy high edges 0–6.
- A=B=1..8 → result=204; operands observed in order (1,2,1,2), (3,4,3,4), …, then zeros after edge 4.
- A=all 0xFFFFFFFF, B=all 1 → result=0xFFFFFFF8 (mod-2^32 wrap).
- Start a run, then assert rst at edge 3 → all outputs 0 on the next cycle, no done pulse. A fresh start then gives the correct result.
- While busy: write A[0]=99 and pulse start → both ignored; result is unchanged from the loaded data.
- start asserted in the done cycle → second run is accepted with no idle gap; its done follows 7 cycles later with the correct result.

Source files
------------

// File: rtl/dot_pkg.sv
// Shared types and constants for the dot-product operand feeder.
package dot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    localparam int unsigned LAT_DEFAULT = 2;
    localparam int unsigned OPW         = 32;

endpackage

// File: rtl/dot_operand_buf.sv
// Dual DEPTH x 32 vector store: one write port, reads element pair (2k, 2k+1) of both vectors.
module dot_operand_buf
    import dot_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     sel,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [OPW-1:0]           wdata,
    input  logic [$clog2(DEPTH)-1:0] pair,
    output logic [OPW-1:0]           a_lo,
    output logic [OPW-1:0]           a_hi,
    output logic [OPW-1:0]           b_lo,
    output logic [OPW-1:0]           b_hi
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [OPW-1:0] mem_a [DEPTH];
    logic [OPW-1:0] mem_b [DEPTH];
    logic [AW-1:0]  lo_idx;
    logic [AW-1:0]  hi_idx;

    // Contents survive reset; software reloads vectors explicitly.
    always_ff @(posedge clk) begin
        if (we) begin
            if (sel) mem_b[waddr] <= wdata;
            else     mem_a[waddr] <= wdata;
        end
    end

    always_comb begin
        lo_idx = AW'({pair, 1'b0});
        hi_idx = AW'({pair, 1'b1});
        a_lo   = mem_a[lo_idx];
        a_hi   = mem_a[hi_idx];
        b_lo   = mem_b[lo_idx];
        b_hi   = mem_b[hi_idx];
    end

endmodule

// File: rtl/dot_feeder.sv
// Issues vector element pairs to the two-lane multiply-add pipeline and accumulates its C output.
module dot_feeder
    import dot_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LAT   = LAT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     wr_sel,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [31:0]              wr_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              result,
    output logic [31:0]              A1,
    output logic [31:0]              A2,
    output logic [31:0]              B1,
    output logic [31:0]              B2,
    input  logic [31:0]              C
);

    localparam int unsigned P  = DEPTH / 2;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(P + 1);

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic [LAT:0]   vld;
    logic [31:0]    acc;
    logic           begin_run;
    logic           issue_pair;
    logic           last_add;
    logic [AW-1:0]  rd_pair;
    logic [31:0]    a_lo, a_hi, b_lo, b_hi;

    dot_operand_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (clk),
        .we    (wr_en & ~busy),
        .sel   (wr_sel),
        .waddr (wr_addr),
        .wdata (wr_data),
        .pair  (rd_pair),
        .a_lo  (a_lo),
        .a_hi  (a_hi),
        .b_lo  (b_lo),
        .b_hi  (b_hi)
    );

    // cnt holds the index of the next pair to load; pair 0 is loaded by the start edge.
    always_comb begin
        state_nx   = state;
        begin_run  = 1'b0;
        issue_pair = 1'b0;
        last_add   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx   = ISSUE;
                    begin_run  = 1'b1;
                    issue_pair = 1'b1;
                end
            end
            ISSUE: begin
                if (cnt == CW'(P)) state_nx = DRAIN;
                else               issue_pair = 1'b1;
            end
            DRAIN: begin
                // Oldest tag set with nothing behind it: this is the last pair's C.
                if (vld[LAT] && !vld[LAT-1]) begin
                    state_nx = IDLE;
                    last_add = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        rd_pair = (state == IDLE) ? '0 : AW'(cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            A1     <= '0;
            A2     <= '0;
            B1     <= '0;
            B2     <= '0;
            acc    <= '0;
            cnt    <= '0;
            vld    <= '0;
        end else begin
            state <= state_nx;
            done  <= last_add;
            vld   <= {vld[LAT-1:0], issue_pair};
            if (begin_run) begin
                busy <= 1'b1;
                acc  <= '0;
                cnt  <= CW'(1);
            end else begin
                if (issue_pair) cnt <= cnt + CW'(1);
                if (vld[LAT])   acc <= acc + C;
            end
            if (last_add) begin
                busy   <= 1'b0;
                result <= acc + C;
            end
            if (issue_pair) begin
                A1 <= a_lo;
                A2 <= a_hi;
                B1 <= b_lo;
                B2 <= b_hi;
            end else begin
                A1 <= '0;
                A2 <= '0;
                B1 <= '0;
                B2 <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dot_feeder.sv
// Directed bench for dot_feeder paired with a 2-edge multiply-add pipeline model.
module tb_dot_feeder;

    localparam int DEPTH = 8;
    localparam int P     = DEPTH / 2;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        wr_sel;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] A1, A2, B1, B2;
    logic [31:0] C  = '0;
    logic [31:0] p1 = '0;
    logic [31:0] p2 = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Partner pipeline: operands captured on one edge, C updated on the next.
    always @(posedge clk) begin
        p1 <= A1 * B1;
        p2 <= A2 * B2;
        C  <= p1 + p2;
    end

    dot_feeder #(
        .DEPTH (DEPTH),
        .LAT   (LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .A1      (A1),
        .A2      (A2),
        .B1      (B1),
        .B2      (B2),
        .C       (C)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input int addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 3'(addr);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    // Pulses start and follows edges 0..P+LAT; ops checks operands for A=B=1..8,
    // inj drives a write of A[0]=99 and a start pulse onto edge 3 while busy.
    task automatic run(input string tag, input logic [31:0] exp, input bit ops, input bit inj);
        start = 1'b1;
        for (int e = 0; e <= P + LAT; e++) begin
            tick();
            if (e == 0) start = 1'b0;
            if (inj && e == 2) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = 32'd99; start = 1'b1;
            end
            if (inj && e == 3) begin
                wr_en = 1'b0; start = 1'b0;
            end
            if (ops) begin
                chk($sformatf("%s_A1_e%0d", tag, e), A1, (e < P) ? 32'(2*e+1) : 32'd0);
                chk($sformatf("%s_A2_e%0d", tag, e), A2, (e < P) ? 32'(2*e+2) : 32'd0);
                chk($sformatf("%s_B1_e%0d", tag, e), B1, (e < P) ? 32'(2*e+1) : 32'd0);
                chk($sformatf("%s_B2_e%0d", tag, e), B2, (e < P) ? 32'(2*e+2) : 32'd0);
            end
            if (e < P + LAT) begin
                chk($sformatf("%s_busy_e%0d", tag, e), 32'(busy), 32'd1);
                chk($sformatf("%s_done_e%0d", tag, e), 32'(done), 32'd0);
            end else begin
                chk($sformatf("%s_done", tag), 32'(done), 32'd1);
                chk($sformatf("%s_busy_end", tag), 32'(busy), 32'd0);
                chk($sformatf("%s_result", tag), result, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_ops", A1 | A2 | B1 | B2, 32'd0);
        rst = 1'b0;
        tick();

        // A=1..8, B=1 -> 36
        for (int i = 0; i < DEPTH; i++) begin
            wr(1'b0, i, 32'(i + 1));
            wr(1'b1, i, 32'd1);
        end
        run("sum", 32'd36, 1'b0, 1'b0);
        tick();
        chk("sum_done_low", 32'(done), 32'd0);
        chk("sum_held", result, 32'd36);

        // A=B=1..8 -> 204, operand order checked
        for (int i = 0; i < DEPTH; i++) wr(1'b1, i, 32'(i + 1));
        run("sq", 32'd204, 1'b1, 1'b0);
        tick();

        // reset at edge 3 of a run
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_result", result, 32'd0);
        chk("mrst_ops", A1 | A2 | B1 | B2, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("mrst_nodone_%0d", i), 32'(done), 32'd0);
        end
        run("after_rst", 32'd204, 1'b0, 1'b0);
        tick();

        // write and start while busy are ignored; rerun confirms A[0] intact
        for (int i = 0; i < DEPTH; i++) wr(1'b1, i, 32'd1);
        run("busy_wr", 32'd36, 1'b0, 1'b1);
        tick();
        chk("busy_wr_idle", 32'(busy), 32'd0);
        run("busy_rerun", 32'd36, 1'b0, 1'b0);

        // start in the done cycle -> back-to-back run
        run("b2b", 32'd36, 1'b0, 1'b0);
        tick();

        // mod 2^32 wrap
        for (int i = 0; i < DEPTH; i++) wr(1'b0, i, 32'hFFFF_FFFF);
        run("wrap", 32'hFFFF_FFF8, 1'b0, 1'b0);
        tick();
        chk("wrap_held", result, 32'hFFFF_FFF8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
